// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM capture block.
package pwm_pkg;

    localparam int CW_DEFAULT   = 16;
    localparam int FILTER_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HIGH,
        LOW
    } pwm_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result and handshake bundle between pwm_capture (master) and its consumer (slave).
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);

    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic          valid;
    logic          ack;
    logic          overrun;
    logic          stuck;
    logic          stuck_lvl;

    modport master (
        output period, high, valid, overrun, stuck, stuck_lvl,
        input  ack
    );

    modport slave (
        input  period, high, valid, overrun, stuck, stuck_lvl,
        output ack
    );

endinterface

// File: rtl/pwm_sync.sv
// Two-flop synchronizer bringing the asynchronous PWM input into the ck domain.
module pwm_sync (
    input  logic ck,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture with valid/ack handshake, overrun and stuck detection.
// Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          en,
    input  logic          pwm_in,
    pwm_capture_if.master res
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          sync_lvl;
    logic          lvl;
    logic          lvl_q;
    logic          rise;
    logic          fall;
    logic          sat;
    pwm_state_t    state;
    pwm_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] high_cap;
    logic [CW-1:0] period_r;
    logic [CW-1:0] high_r;
    logic          valid_r;
    logic          overrun_r;
    logic          stuck_r;
    logic          stuck_lvl_r;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cap_high;
    logic          publish;
    logic          set_stuck;

    pwm_sync u_sync (
        .ck    (ck),
        .rst_n (rst_n),
        .d     (pwm_in),
        .q     (sync_lvl)
    );

`ifdef PWM_CAPTURE_FILTER_EN
    // A new level is only accepted once the last FILTER_DEPTH samples agree.
    logic [FILTER_DEPTH-2:0] hist;
    logic                    filt_q;

    assign lvl = (hist == {(FILTER_DEPTH-1){sync_lvl}}) ? sync_lvl : filt_q;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[FILTER_DEPTH-3:0], sync_lvl};
            filt_q <= lvl;
        end
    end
`else
    assign lvl = sync_lvl;
`endif

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            lvl_q <= lvl;
            rise  <= lvl & ~lvl_q;
            fall  <= ~lvl & lvl_q;
        end
    end

    assign sat = (cnt == CNT_MAX);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Saturation outranks edges so a wrapped count is never reported.
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = SYNC;
                SYNC: if (!sat && rise) state_nx = HIGH;
                HIGH: if (sat) state_nx = SYNC; else if (fall) state_nx = LOW;
                LOW:  if (sat) state_nx = SYNC; else if (rise) state_nx = HIGH;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cap_high  = 1'b0;
        publish   = 1'b0;
        set_stuck = 1'b0;
        if (!en || state == IDLE) begin
            cnt_clr = 1'b1;
        end else if (sat) begin
            cnt_clr   = 1'b1;
            set_stuck = 1'b1;
        end else begin
            case (state)
                SYNC: begin
                    cnt_clr = rise;
                    cnt_inc = ~rise;
                end
                HIGH: begin
                    cnt_inc  = 1'b1;
                    cap_high = fall;
                end
                LOW: begin
                    publish = rise;
                    cnt_clr = rise;
                    cnt_inc = ~rise;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            high_cap    <= '0;
            period_r    <= '0;
            high_r      <= '0;
            valid_r     <= 1'b0;
            overrun_r   <= 1'b0;
            stuck_r     <= 1'b0;
            stuck_lvl_r <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (cap_high) high_cap <= cnt + 1'b1;

            if (publish) begin
                period_r <= cnt + 1'b1;
                high_r   <= high_cap;
                if (valid_r && !res.ack) overrun_r <= 1'b1;
            end else if (res.ack && valid_r) begin
                overrun_r <= 1'b0;
            end

            if (!en)                      valid_r <= 1'b0;
            else if (publish)             valid_r <= 1'b1;
            else if (res.ack && valid_r)  valid_r <= 1'b0;

            if (!en) begin
                stuck_r <= 1'b0;
            end else if (set_stuck) begin
                stuck_r     <= 1'b1;
                stuck_lvl_r <= lvl;
            end else if (rise) begin
                stuck_r <= 1'b0;
            end
        end
    end

    assign res.period    = period_r;
    assign res.high      = high_r;
    assign res.valid     = valid_r;
    assign res.overrun   = overrun_r;
    assign res.stuck     = stuck_r;
    assign res.stuck_lvl = stuck_lvl_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM traffic scored against an event-level model of the
// expected results (period/high per rise pair, delivered a fixed latency later).
`timescale 1ns/1ps
module tb_pwm_capture;
    import pwm_pkg::*;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = 6;
    localparam int MINW = 3;
`else
    localparam int LAT  = 4;
    localparam int MINW = 1;
`endif

    typedef struct {
        int due;
        int per;
        int hi;
    } result_t;

    logic ck     = 1'b0;
    logic rst_n  = 1'b0;
    logic en     = 1'b0;
    logic pwm_in = 1'b0;
    logic en8    = 1'b0;
    logic pwm8   = 1'b0;

    pwm_capture_if #(.CW(16)) bus ();
    pwm_capture_if #(.CW(8))  bus8 ();

    pwm_capture #(.CW(16)) u_dut (
        .ck     (ck),
        .rst_n  (rst_n),
        .en     (en),
        .pwm_in (pwm_in),
        .res    (bus)
    );

    pwm_capture #(.CW(8)) u_dut8 (
        .ck     (ck),
        .rst_n  (rst_n),
        .en     (en8),
        .pwm_in (pwm8),
        .res    (bus8)
    );

    always #5 ck = ~ck;

    int      total;
    int      bad;
    int      cyc;
    int      ack_mode;
    int      t_rise;
    int      t_fall;
    bit      have_start;
    bit      saw_fall;
    bit      exp_valid;
    bit      exp_ovr;
    int      exp_per;
    int      exp_hi;
    logic    prev_pwm;
    result_t pend[$];

    task automatic check_output(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        exp_valid  = 1'b0;
        exp_ovr    = 1'b0;
        exp_per    = 0;
        exp_hi     = 0;
        have_start = 1'b0;
        saw_fall   = 1'b0;
        pend.delete();
    endfunction

    // One ck cycle: score the edge, drive new inputs, then compare at the falling edge.
    task automatic apply_stimulus(input logic p, input logic e);
        result_t r;
        logic    a;
        @(posedge ck);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            exp_valid  = 1'b0;
            have_start = 1'b0;
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (exp_valid && !bus.ack) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            exp_per   = r.per;
            exp_hi    = r.hi;
        end else if (bus.ack && exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end

        case (ack_mode)
            1:       a = exp_valid;
            2:       a = 1'($urandom_range(0, 1));
            3:       a = (pend.size() > 0 && pend[0].due == cyc + 1);
            default: a = 1'b0;
        endcase

        #1;
        pwm_in  = p;
        en      = e;
        bus.ack = a;
        if (p && !prev_pwm) begin
            if (have_start && saw_fall) begin
                r.due = cyc + LAT;
                r.per = cyc - t_rise;
                r.hi  = t_fall - t_rise;
                pend.push_back(r);
            end
            have_start = 1'b1;
            saw_fall   = 1'b0;
            t_rise     = cyc;
        end else if (!p && prev_pwm && have_start) begin
            saw_fall = 1'b1;
            t_fall   = cyc;
        end
        prev_pwm = p;

        @(negedge ck);
        check_output("valid",   bus.valid,   exp_valid);
        check_output("overrun", bus.overrun, exp_ovr);
        check_output("period",  bus.period,  exp_per);
        check_output("high",    bus.high,    exp_hi);
        check_output("stuck",   bus.stuck,   0);
    endtask

    task automatic drive_pulse(input int h, input int l);
        repeat (h) apply_stimulus(1'b1, 1'b1);
        repeat (l) apply_stimulus(1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n8;
        int  k8;
        bit  seen8;
        bit  valid8_seen;

        total    = 0;
        bad      = 0;
        cyc      = 0;
        ack_mode = 0;
        prev_pwm = 1'b0;
        model_reset();
        bus.ack  = 1'b0;
        bus8.ack = 1'b0;

        repeat (3) @(posedge ck);
        #1;
        check_output("rst_valid",   bus.valid,   0);
        check_output("rst_period",  bus.period,  0);
        check_output("rst_high",    bus.high,    0);
        check_output("rst_overrun", bus.overrun, 0);
        check_output("rst_stuck",   bus.stuck,   0);
        check_output("rst8_stuck",  bus8.stuck,  0);
        rst_n = 1'b1;

        // Three clean 30/70 periods with no ack, then a closing rise.
        repeat (8) apply_stimulus(1'b0, 1'b1);
        repeat (3) drive_pulse(30, 70);
        drive_pulse(30, 10);
        check_output("r035_period",  bus.period,  100);
        check_output("r035_high",    bus.high,    30);
        check_output("r035_overrun", bus.overrun, 1);
        check_output("r035_valid",   bus.valid,   1);

        ack_mode = 1;
`ifndef PWM_CAPTURE_FILTER_EN
        repeat (10) drive_pulse(1, 1);
        repeat (6) apply_stimulus(1'b0, 1'b1);
        check_output("r036_period",  bus.period,  2);
        check_output("r036_high",    bus.high,    1);
        check_output("r036_overrun", bus.overrun, 0);
`endif

        // Every result lands in the same cycle as an ack.
        ack_mode = 3;
        repeat (3) drive_pulse(20, 20);
        check_output("r038_valid",   bus.valid,   1);
        check_output("r038_overrun", bus.overrun, 0);
        check_output("r038_period",  bus.period,  40);
        check_output("r038_high",    bus.high,    20);

        ack_mode = 2;
        repeat (40) drive_pulse($urandom_range(MINW, 12), $urandom_range(MINW, 12));

        // Drop en for 5 cycles in the middle of a low phase.
        ack_mode = 0;
        repeat (2) drive_pulse(10, 10);
        repeat (10) apply_stimulus(1'b1, 1'b1);
        repeat (15) apply_stimulus(1'b0, 1'b1);
        repeat (5) apply_stimulus(1'b0, 1'b0);
        check_output("r040_valid",  bus.valid,  0);
        check_output("r040_period", bus.period, 20);
        check_output("r040_high",   bus.high,   10);
        repeat (15) apply_stimulus(1'b0, 1'b1);
        drive_pulse(12, 8);
        check_output("r040_novalid", bus.valid, 0);
        drive_pulse(12, 8);
        drive_pulse(5, 5);
        check_output("r040_period2", bus.period, 20);
        check_output("r040_high2",   bus.high,   12);

        // Asynchronous reset in the middle of a high phase.
        ack_mode = 1;
        repeat (2) drive_pulse(10, 10);
        repeat (5) apply_stimulus(1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("r039_valid",     bus.valid,     0);
        check_output("r039_period",    bus.period,    0);
        check_output("r039_high",      bus.high,      0);
        check_output("r039_overrun",   bus.overrun,   0);
        check_output("r039_stuck",     bus.stuck,     0);
        check_output("r039_stuck_lvl", bus.stuck_lvl, 0);
        model_reset();
        repeat (3) apply_stimulus(1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (8) apply_stimulus(1'b0, 1'b1);
        drive_pulse(10, 15);
        check_output("r039_novalid", bus.valid, 0);
        drive_pulse(10, 15);
        drive_pulse(7, 7);
        check_output("r039_period2", bus.period, 25);
        check_output("r039_high2",   bus.high,   10);

        // 8-bit instance: input held high must saturate the counter.
        seen8       = 1'b0;
        valid8_seen = 1'b0;
        n8          = 0;
        k8          = 0;
        @(posedge ck);
        #1;
        en8  = 1'b1;
        pwm8 = 1'b1;
        while (!seen8 && n8 < 400) begin
            @(negedge ck);
            n8++;
            if (bus8.valid) valid8_seen = 1'b1;
            if (bus8.stuck) begin
                seen8 = 1'b1;
                k8    = n8 - 1;
            end
        end
        check_output("r037_stuck_seen", seen8, 1);
        check_output("r037_stuck_not_early", int'(k8 >= 255), 1);
        check_output("r037_stuck_not_late",  int'(k8 <= 265), 1);
        check_output("r037_stuck_lvl", bus8.stuck_lvl, 1);

        pwm8 = 1'b0;
        repeat (10) begin
            @(negedge ck);
            if (bus8.valid) valid8_seen = 1'b1;
        end
        check_output("r037_stuck_hold", bus8.stuck, 1);
        pwm8  = 1'b1;
        seen8 = 1'b0;
        n8    = 0;
        while (!seen8 && n8 < 12) begin
            @(negedge ck);
            n8++;
            if (bus8.valid) valid8_seen = 1'b1;
            if (!bus8.stuck) seen8 = 1'b1;
        end
        check_output("r037_stuck_clear", seen8, 1);
        check_output("r037_no_valid", valid8_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requires

Module: pwm_capture

Interface
REQ-001 Parameter CW, default 16: width of the cycle counters and result ports.
REQ-002 Port ck, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port en, input, 1: measurement enable, synchronous to ck.
REQ-005 Port pwm_in, input, 1: PWM waveform, asynchronous to ck.
REQ-006 Port period, output, CW: last measured period in ck cycles (rise to rise).
REQ-007 Port high, output, CW: high time in ck cycles (rise to fall) of the same period.
REQ-008 Port valid, output, 1: new period/high result available; held until ack.
REQ-009 Port ack, input, 1: consumer accepts the result; clears valid.
REQ-010 Port overrun, output, 1: sticky; a result was overwritten while valid=1.
REQ-011 Port stuck, output, 1: no pwm_in edge within 2^CW-1 cycles.
REQ-012 Port stuck_lvl, output, 1: pwm_in level while stuck=1.

Function
REQ-013 pwm_in SHALL pass through a two-flop synchronizer; rise/fall events come from a third registered sample.
REQ-014 FSM states: IDLE, SYNC, HIGH, LOW; en=0 forces IDLE from any state on the next edge.
REQ-015 IDLE: counter held at 0; en=1 -> SYNC.
REQ-016 SYNC: wait for rise event; falls ignored; rise -> HIGH, counter cleared.
REQ-017 HIGH: counter increments each cycle; fall -> LOW, high-time captured internally.
REQ-018 LOW: counter increments; rise -> HIGH, period and high updated, valid=1, counter cleared.
REQ-019 For a clean input with H high and L low cycles, period SHALL equal H+L and high SHALL equal H exactly.
REQ-020 First result follows the second rise after entering SYNC; a partial first period is never reported.
REQ-021 valid SHALL rise exactly 4 ck cycles after the ck-aligned pwm_in rising edge.
REQ-022 ack with valid=1 clears valid next cycle; ack with valid=0 has no effect.
REQ-023 A new result while valid=1 with no ack same cycle: outputs overwritten, valid stays 1, overrun set.
REQ-024 A new result in the same cycle as ack: new result wins, valid stays 1, overrun unchanged.
REQ-025 overrun clears only on ack or reset.
REQ-026 Counter saturation at 2^CW-1 in HIGH, LOW or SYNC: stuck=1, stuck_lvl=synced level, FSM -> SYNC, counter cleared; no result produced.
REQ-027 stuck clears on the next rise event.
REQ-028 en=0 clears valid, stuck and counter; period/high hold their last values.

Reset
REQ-029 rst_n=0 SHALL asynchronously set state=IDLE and zero the counter, synchronizer flops, period, high, valid, overrun, stuck and stuck_lvl.
REQ-030 Reset mid-measurement discards the partial period; the first post-reset result obeys REQ-020.

Configuration
REQ-031 Macro PWM_CAPTURE_FILTER_EN defined: a glitch filter accepts a new synced level only after 3 consecutive equal samples; REQ-021 latency becomes 6 cycles; pulses shorter than 3 cycles are ignored.
REQ-032 Macro undefined: no filter; latency per REQ-021; a 1-cycle pulse is a valid edge pair.

Structure
REQ-033 Shared package pwm_pkg SHALL hold the CW default, the FSM state enumeration and the filter depth constant (3).
REQ-034 The two-flop synchronizer SHALL be a separate sub-module, pwm_sync.

Verification
REQ-035 CW=16, H=30, L=70, repeated 3 periods, no ack -> first valid after second rise, period=100, high=30, overrun=1 after third rise.
REQ-036 H=1, L=1, ack each valid -> period=2, high=1 each result, overrun stays 0; with PWM_CAPTURE_FILTER_EN, no valid and eventually stuck=1.
REQ-037 CW=8, pwm_in held 1 -> stuck=1, stuck_lvl=1 after 255 cycles; next rise clears stuck; no valid.
REQ-038 ack in the same cycle as a new result -> valid stays 1, overrun=0, period shows the new value.
REQ-039 rst_n pulsed low mid HIGH phase -> all outputs 0 immediately; next valid after two full post-reset rises.
REQ-040 en dropped for 5 cycles mid-period -> valid=0, period/high hold; no result until two rises after en returns.
